ama_riscv_icache: RTL

Direct-mapped, read-only instruction cache that serves the front-end fetch port. It is the responder for `imem_req` and the producer of `imem_rsp`. Hits return one 32-bit instruction per cycle. Misses stall the front end by deasserting request ready, refill a 64 B line from backing memory in 4 × 128-bit beats, then return the requested word. It sits between the front-end control and the memory interconnect.

---
 rtl/ama_riscv_icache_pkg.sv | 31 +++
 rtl/rv_if.sv | 15 +
 rtl/ama_riscv_icache_array.sv | 77 +++++++
 rtl/ama_riscv_icache.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ama_riscv_icache_pkg.sv
// Shared constants, state encoding and geometry helpers for the instruction cache.
// Geometry: 64 B lines of 16 words, refilled as 4 x 128-bit beats.
// Address split: [1:0] byte (ignored), [5:2] word, [5+log2(SETS):6] index, rest tag.
package ama_riscv_icache_pkg;

  localparam int ICACHE_LINE_BYTES = 64;
  localparam int ICACHE_BEATS      = 4;
  localparam int MEM_BUS_W         = 128;
  localparam int ICACHE_WORDS      = ICACHE_LINE_BYTES / 4;
  localparam int ICACHE_OFFSET_W   = 6;

  // FSM encoding, kept as plain localparam constants of a 2-bit type.
  typedef logic [1:0] icache_state_t;
  localparam icache_state_t ST_IDLE     = 2'd0;
  localparam icache_state_t ST_MISS_REQ = 2'd1;
  localparam icache_state_t ST_REFILL   = 2'd2;
  localparam icache_state_t ST_RESP     = 2'd3;

  function automatic int icache_index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int icache_tag_w(input int sets);
    return 32 - ICACHE_OFFSET_W - $clog2(sets);
  endfunction

  function automatic int icache_word_w();
    return $clog2(ICACHE_WORDS);
  endfunction

endpackage

// File: rtl/rv_if.sv
// Generic ready/valid channel.
// Handshake: a transfer happens on a rising edge where valid && ready. Once the
// sender raises valid it holds valid and data stable until that transfer; the
// receiver may raise or drop ready freely.
//   valid : sender -> receiver
//   ready : receiver -> sender
//   data  : sender -> receiver, W bits
interface rv_if #(parameter int W = 32);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport TX (output valid, output data, input ready);
  modport RX (input valid, input data, output ready);
endinterface

// File: rtl/ama_riscv_icache_array.sv
// Storage for the direct-mapped instruction cache: per line a valid bit, a tag
// and 16 x 32-bit words, all in flops. Only the valid bits are reset.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (clears valid bits)
//   rd_addr          : lookup address (combinational read)
//   rd_hit, rd_word  : lookup result and addressed word
//   wr_en            : write one 128-bit refill beat
//   wr_idx, wr_beat  : line index and beat number (words 4*beat .. 4*beat+3)
//   wr_data          : beat payload, lowest word in bits [31:0]
//   wr_last          : with wr_en, final beat: set valid and write the tag
//   wr_tag           : tag written on the final beat
//   inv_all          : clear every valid bit
module ama_riscv_icache_array
  import ama_riscv_icache_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int IDX_W = icache_index_w(SETS),
  parameter int TAG_W = icache_tag_w(SETS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          rd_addr,
  output logic                 rd_hit,
  output logic [31:0]          rd_word,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [1:0]           wr_beat,
  input  logic [MEM_BUS_W-1:0] wr_data,
  input  logic                 wr_last,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic                 inv_all
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][ICACHE_WORDS];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [3:0]       rd_wsel;
  logic             unused_rd_lsb;

  assign rd_idx        = rd_addr[ICACHE_OFFSET_W +: IDX_W];
  assign rd_tag        = rd_addr[31 -: TAG_W];
  assign rd_wsel       = rd_addr[5:2];
  // Byte offset within a word is irrelevant for 32-bit fetches.
  assign unused_rd_lsb = ^rd_addr[1:0];

  always_comb begin
    rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_word = data_q[rd_idx][rd_wsel];
  end

  // Invalidate and the final refill beat never coincide: invalidation only
  // happens while the controller is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (inv_all) begin
      valid_q <= '0;
    end else if (wr_en && wr_last) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        data_q[wr_idx][{wr_beat, 2'(b)}] <= wr_data[32*b +: 32];
      end
      if (wr_last) begin
        tag_q[wr_idx] <= wr_tag;
      end
    end
  end

endmodule

// File: rtl/ama_riscv_icache.sv
// Direct-mapped read-only instruction cache between the fetch front end and
// the memory interconnect. Hits answer one cycle after accept; misses fetch a
// 64 B line in four 128-bit beats and then answer with the requested word.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   imem_req   : fetch address in (valid from FE, ready from cache)
//   imem_rsp   : instruction out (valid from cache, ready from FE)
//   mem_req    : line-aligned refill address out
//   mem_rsp    : refill beats in, ascending, beat 0 = line bytes 0..15
//   inv        : single-cycle invalidate-all request (fence.i)
//   dbg_state  : current FSM state
module ama_riscv_icache
  import ama_riscv_icache_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic          clk,
  input  logic          rst,
  rv_if.RX              imem_req,
  rv_if.TX              imem_rsp,
  rv_if.TX              mem_req,
  rv_if.RX              mem_rsp,
  input  logic          inv,
  output icache_state_t dbg_state
);

  localparam int IDX_W = icache_index_w(SETS);
  localparam int TAG_W = icache_tag_w(SETS);

  icache_state_t state_q;
  logic [1:0]    cnt_q;
  logic [31:2]   miss_addr_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_data_q;
  logic          inv_pend_q;

  logic          idle;
  logic          rsp_stall;
  logic          req_ready;
  logic          accept;
  logic          inv_clr;
  logic          beat_hs;
  logic          lookup_hit;
  logic [31:0]   lookup_word;
  logic [31:0]   beat_word;

  assign idle      = (state_q == ST_IDLE);
  // A presented response that the FE has not taken blocks everything new.
  assign rsp_stall = rsp_valid_q && !imem_rsp.ready;
  assign req_ready = idle && !rsp_stall && !inv_pend_q && !rst;
  assign accept    = imem_req.valid && req_ready;
  // Pending invalidate fires in the first quiet idle cycle; a miss in flight
  // therefore completes and returns its word before the flush.
  assign inv_clr   = idle && !rsp_stall && inv_pend_q;
  assign beat_hs   = (state_q == ST_REFILL) && mem_rsp.valid;
  assign beat_word = mem_rsp.data[{miss_addr_q[3:2], 5'b0} +: 32];

  assign imem_req.ready = req_ready;
  assign imem_rsp.valid = rsp_valid_q;
  assign imem_rsp.data  = rsp_data_q;
  assign mem_req.valid  = (state_q == ST_MISS_REQ);
  assign mem_req.data   = {miss_addr_q[31:6], 6'b0};
  assign mem_rsp.ready  = (state_q == ST_REFILL);
  assign dbg_state      = state_q;

  ama_riscv_icache_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (imem_req.data),
    .rd_hit  (lookup_hit),
    .rd_word (lookup_word),
    .wr_en   (beat_hs),
    .wr_idx  (miss_addr_q[ICACHE_OFFSET_W +: IDX_W]),
    .wr_beat (cnt_q),
    .wr_data (mem_rsp.data),
    .wr_last (cnt_q == 2'd3),
    .wr_tag  (miss_addr_q[31 -: TAG_W]),
    .inv_all (inv_clr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      inv_pend_q  <= 1'b0;
    end else begin
      inv_pend_q <= inv || (inv_pend_q && !inv_clr);
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rsp_valid_q <= lookup_hit;
            if (!lookup_hit) begin
              state_q <= ST_MISS_REQ;
            end
          end else if (imem_rsp.ready) begin
            rsp_valid_q <= 1'b0;
          end
        end
        ST_MISS_REQ: begin
          if (mem_req.ready) begin
            state_q <= ST_REFILL;
            cnt_q   <= '0;
          end
        end
        ST_REFILL: begin
          if (mem_rsp.valid) begin
            cnt_q <= cnt_q + 2'd1;
            // Response goes out the cycle after the last beat, never with it.
            if (cnt_q == 2'd3) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (imem_rsp.ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Response data and miss address need no reset: they are qualified by
  // rsp_valid_q and the FSM state respectively.
  always_ff @(posedge clk) begin
    if (accept && lookup_hit) begin
      rsp_data_q <= lookup_word;
    end else if (beat_hs && (cnt_q == miss_addr_q[5:4])) begin
      rsp_data_q <= beat_word;
    end
    if (accept) begin
      miss_addr_q <= imem_req.data[31:2];
    end
  end

endmodule
